// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types, constants and BCD helpers for the multi-channel
// alarm unit.
//   alarm_state_t  : per-channel state (IDLE, RINGING, SNOOZED)
//   BCD_H_MAX/M_MAX: largest legal packed-BCD hour / minute
//   bcd_add_min()  : add n minutes to a BCD hour:minute, wrapping 23:59 -> 00:00
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    localparam logic [7:0] BCD_H_MAX = 8'h23;
    localparam logic [7:0] BCD_M_MAX = 8'h59;

    function automatic logic [7:0] bcd_to_bin(input logic [7:0] b);
        return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
    endfunction

    // Only ever called with values below 100, so two digits suffice.
    function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
        logic [7:0] tens;
        tens = v / 8'd10;
        return 8'((tens << 4) | (v - tens * 8'd10));
    endfunction

    // Returns {hour, minute} in packed BCD. n is binary minutes (< 60).
    function automatic logic [15:0] bcd_add_min(input logic [7:0] h,
                                                input logic [7:0] m,
                                                input logic [7:0] n);
        logic [8:0] m_sum;
        logic [7:0] h_bin;
        m_sum = 9'(bcd_to_bin(m)) + 9'(n);
        h_bin = bcd_to_bin(h);
        if (m_sum >= 9'd60) begin
            m_sum = m_sum - 9'd60;
            h_bin = h_bin + 8'd1;
        end
        if (h_bin >= 8'd24) begin
            h_bin = h_bin - 8'd24;
        end
        return {bin_to_bcd(h_bin), bin_to_bcd(m_sum[7:0])};
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm channel -- setting registers, snooze target,
// ring/snooze counters and the IDLE/RINGING/SNOOZED state machine.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick                  : 1 Hz enable (one clk cycle)
//   time_h/m/s            : running time, packed BCD
//   we, d_h, d_m, d_en    : write strobe (already decoded for this channel) + data
//   stop_evt, snooze_evt  : registered button rising edges, shared by all channels
//   alm_h, alm_m, alm_en  : stored setting for readback
//   ring                  : registered "state is RINGING"
//   ring_next             : value ring takes on the next edge (feeds the top-level OR)
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_S     = 60,
    parameter int SNOOZE_M   = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] time_h,
    input  logic [7:0] time_m,
    input  logic [7:0] time_s,
    input  logic       we,
    input  logic [7:0] d_h,
    input  logic [7:0] d_m,
    input  logic       d_en,
    input  logic       stop_evt,
    input  logic       snooze_evt,
    output logic [7:0] alm_h,
    output logic [7:0] alm_m,
    output logic       alm_en,
    output logic       ring,
    output logic       ring_next
);

    alarm_state_t state_reg, state_next;
    logic [7:0]   alm_h_reg, alm_h_next;
    logic [7:0]   alm_m_reg, alm_m_next;
    logic         en_reg, en_next;
    logic [7:0]   tgt_h_reg, tgt_h_next;
    logic [7:0]   tgt_m_reg, tgt_m_next;
    logic [7:0]   ring_cnt_reg, ring_cnt_next;
    logic [7:0]   snz_cnt_reg, snz_cnt_next;
    logic         ring_reg;

    logic         sec_zero;
    logic         alarm_hit;
    logic         target_hit;
    logic         ring_done;
    logic [15:0]  snz_tgt;

    assign sec_zero = tick && (time_s == 8'h00);

    // The range guard keeps a stored out-of-range setting inert even if the
    // time source were ever to present an illegal value.
    assign alarm_hit = sec_zero && en_reg
                       && (alm_h_reg == time_h) && (alm_m_reg == time_m)
                       && (alm_h_reg <= BCD_H_MAX) && (alm_m_reg <= BCD_M_MAX);

    assign target_hit = sec_zero && (tgt_h_reg == time_h) && (tgt_m_reg == time_m);

    // Counter was cleared on the trigger tick, so the RING_S-th tick after it
    // is the one that sees ring_cnt == RING_S-1.
    assign ring_done = ({1'b0, ring_cnt_reg} + 9'd1) == 9'(RING_S);

    assign snz_tgt = bcd_add_min(time_h, time_m, 8'(SNOOZE_M));

    always_comb begin
        state_next    = state_reg;
        alm_h_next    = alm_h_reg;
        alm_m_next    = alm_m_reg;
        en_next       = en_reg;
        tgt_h_next    = tgt_h_reg;
        tgt_m_next    = tgt_m_reg;
        ring_cnt_next = ring_cnt_reg;
        snz_cnt_next  = snz_cnt_reg;

        // The setting itself is always taken on a write; only the state
        // change it implies is subject to STOP/SNOOZE taking precedence.
        if (we) begin
            alm_h_next = d_h;
            alm_m_next = d_m;
            en_next    = d_en;
        end

        if (stop_evt) begin
            state_next = IDLE;
        end else if (snooze_evt && (state_reg == RINGING)) begin
            if (snz_cnt_reg < 8'(MAX_SNOOZE)) begin
                state_next   = SNOOZED;
                tgt_h_next   = snz_tgt[15:8];
                tgt_m_next   = snz_tgt[7:0];
                snz_cnt_next = snz_cnt_reg + 8'd1;
            end else begin
                state_next = IDLE;
            end
        end else if (we) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (alarm_hit) begin
                        state_next    = RINGING;
                        ring_cnt_next = 8'd0;
                        snz_cnt_next  = 8'd0;
                    end
                end
                RINGING: begin
                    if (tick) begin
                        if (ring_done) begin
                            state_next = IDLE;
                        end else begin
                            ring_cnt_next = ring_cnt_reg + 8'd1;
                        end
                    end
                end
                SNOOZED: begin
                    if (target_hit) begin
                        state_next    = RINGING;
                        ring_cnt_next = 8'd0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign ring_next = (state_next == RINGING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            alm_h_reg    <= 8'h00;
            alm_m_reg    <= 8'h00;
            en_reg       <= 1'b0;
            tgt_h_reg    <= 8'h00;
            tgt_m_reg    <= 8'h00;
            ring_cnt_reg <= 8'd0;
            snz_cnt_reg  <= 8'd0;
            ring_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            alm_h_reg    <= alm_h_next;
            alm_m_reg    <= alm_m_next;
            en_reg       <= en_next;
            tgt_h_reg    <= tgt_h_next;
            tgt_m_reg    <= tgt_m_next;
            ring_cnt_reg <= ring_cnt_next;
            snz_cnt_reg  <= snz_cnt_next;
            ring_reg     <= ring_next;
        end
    end

    assign alm_h  = alm_h_reg;
    assign alm_m  = alm_m_reg;
    assign alm_en = en_reg;
    assign ring   = ring_reg;

endmodule

// File: rtl/alarm_multi.sv
// alarm_multi: N_CH-channel alarm unit beside the time-keeping counters.
// Ports:
//   CP, CR                 : clock (rising edge), asynchronous active-low reset
//   TICK                   : 1 Hz enable, one CP cycle
//   TIME_H/M/S             : running time, packed BCD
//   WE, WADDR, D_H/D_M/D_EN: channel setting write
//   RADDR, Q_H/Q_M/Q_EN    : combinational readback of one channel's setting
//   STOP, SNOOZE           : debounced button levels
//   RING                   : buzzer enable (registered OR of all channels)
//   RING_CH                : per-channel ringing flags (registered)
// Holds the button edge detectors, write decode, readback mux and RING OR;
// the per-channel behaviour lives in alarm_channel.
module alarm_multi
    import alarm_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int RING_S     = 60,
    parameter int SNOOZE_M   = 5,
    parameter int MAX_SNOOZE = 3,
    localparam int AW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CP,
    input  logic            CR,
    input  logic            TICK,
    input  logic [7:0]      TIME_H,
    input  logic [7:0]      TIME_M,
    input  logic [7:0]      TIME_S,
    input  logic            WE,
    input  logic [AW-1:0]   WADDR,
    input  logic [7:0]      D_H,
    input  logic [7:0]      D_M,
    input  logic            D_EN,
    input  logic [AW-1:0]   RADDR,
    output logic [7:0]      Q_H,
    output logic [7:0]      Q_M,
    output logic            Q_EN,
    input  logic            STOP,
    input  logic            SNOOZE,
    output logic            RING,
    output logic [N_CH-1:0] RING_CH
);

    logic stop_d_reg, snooze_d_reg;
    logic stop_evt_reg, snooze_evt_reg;
    logic ring_reg;

    logic [N_CH-1:0] we_sel;
    logic [N_CH-1:0] ring_next_vec;
    logic [7:0]      alm_h_arr [N_CH];
    logic [7:0]      alm_m_arr [N_CH];
    logic [N_CH-1:0] alm_en_vec;

    // Rising edges are captured into a register and acted on one cycle
    // later, giving a fixed two-edge button-to-RING latency. A held button
    // produces a single event because the delayed copy stays high.
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            stop_d_reg     <= 1'b0;
            snooze_d_reg   <= 1'b0;
            stop_evt_reg   <= 1'b0;
            snooze_evt_reg <= 1'b0;
            ring_reg       <= 1'b0;
        end else begin
            stop_d_reg     <= STOP;
            snooze_d_reg   <= SNOOZE;
            stop_evt_reg   <= STOP & ~stop_d_reg;
            snooze_evt_reg <= SNOOZE & ~snooze_d_reg;
            ring_reg       <= |ring_next_vec;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign we_sel[gi] = WE && (WADDR == AW'(gi));

        alarm_channel #(
            .RING_S     (RING_S),
            .SNOOZE_M   (SNOOZE_M),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_ch (
            .clk        (CP),
            .rst_n      (CR),
            .tick       (TICK),
            .time_h     (TIME_H),
            .time_m     (TIME_M),
            .time_s     (TIME_S),
            .we         (we_sel[gi]),
            .d_h        (D_H),
            .d_m        (D_M),
            .d_en       (D_EN),
            .stop_evt   (stop_evt_reg),
            .snooze_evt (snooze_evt_reg),
            .alm_h      (alm_h_arr[gi]),
            .alm_m      (alm_m_arr[gi]),
            .alm_en     (alm_en_vec[gi]),
            .ring       (RING_CH[gi]),
            .ring_next  (ring_next_vec[gi])
        );
    end

    // Unused RADDR codes (N_CH not a power of two) read back as zero.
    always_comb begin
        Q_H  = 8'h00;
        Q_M  = 8'h00;
        Q_EN = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (RADDR == AW'(i)) begin
                Q_H  = alm_h_arr[i];
                Q_M  = alm_m_arr[i];
                Q_EN = alm_en_vec[i];
            end
        end
    end

    assign RING = ring_reg;

endmodule

// File: tb/tb_alarm_multi.sv
// Testbench for alarm_multi: directed stimulus pushes expected RING_CH/Q
// values, stamped with the cycle they must appear in, onto a scoreboard
// queue; a monitor on the falling clock edge pops and compares them.
module tb_alarm_multi;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       TICK = 1'b0;
    logic [7:0] TIME_H = 8'h00, TIME_M = 8'h00, TIME_S = 8'h00;
    logic       WE = 1'b0;
    logic [1:0] WADDR = 2'd0;
    logic [7:0] D_H = 8'h00, D_M = 8'h00;
    logic       D_EN = 1'b0;
    logic [1:0] RADDR = 2'd0;
    logic [7:0] Q_H, Q_M;
    logic       Q_EN;
    logic       STOP = 1'b0, SNOOZE = 1'b0;
    logic       RING;
    logic [3:0] RING_CH;

    always #5 CP = ~CP;

    alarm_multi #(
        .N_CH(4), .RING_S(60), .SNOOZE_M(5), .MAX_SNOOZE(3)
    ) dut (
        .CP(CP), .CR(CR), .TICK(TICK),
        .TIME_H(TIME_H), .TIME_M(TIME_M), .TIME_S(TIME_S),
        .WE(WE), .WADDR(WADDR), .D_H(D_H), .D_M(D_M), .D_EN(D_EN),
        .RADDR(RADDR), .Q_H(Q_H), .Q_M(Q_M), .Q_EN(Q_EN),
        .STOP(STOP), .SNOOZE(SNOOZE), .RING(RING), .RING_CH(RING_CH)
    );

    typedef struct {
        int         stamp;
        string      name;
        logic [3:0] ring_ch;
        bit         chk_q;
        logic [7:0] qh;
        logic [7:0] qm;
        logic       qen;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] th = 8'h00, tm = 8'h00, ts = 8'h00;

    always @(posedge CP) cyc <= cyc + 1;

    function automatic void push(input int delay, input string name, input logic [3:0] rc,
                                 input bit chk_q, input logic [7:0] qh, input logic [7:0] qm,
                                 input logic qen);
        exp_t e;
        e.stamp = cyc + delay;
        e.name = name;
        e.ring_ch = rc;
        e.chk_q = chk_q;
        e.qh = qh;
        e.qm = qm;
        e.qen = qen;
        sb.push_back(e);
    endfunction

    // Monitor: compares every entry whose cycle has come.
    always @(negedge CP) begin
        while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.stamp != cyc || RING_CH !== mon_e.ring_ch || RING !== (|mon_e.ring_ch)) begin
                errors++;
                $display("FAIL %s @cyc %0d: RING_CH=%b RING=%b, required RING_CH=%b RING=%b",
                         mon_e.name, cyc, RING_CH, RING, mon_e.ring_ch, |mon_e.ring_ch);
            end
            if (mon_e.chk_q) begin
                checks++;
                if (Q_H !== mon_e.qh || Q_M !== mon_e.qm || Q_EN !== mon_e.qen) begin
                    errors++;
                    $display("FAIL %s readback @cyc %0d: Q=%h:%h en=%b, required %h:%h en=%b",
                             mon_e.name, cyc, Q_H, Q_M, Q_EN, mon_e.qh, mon_e.qm, mon_e.qen);
                end
            end
        end
    end

    // Digit-wise BCD increment: returns {wrapped, next value}.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        if (v == maxv) return {1'b1, 8'h00};
        if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    task automatic adv_time();
        logic c;
        {c, ts} = bcd_inc(ts, 8'h59);
        if (c) begin
            {c, tm} = bcd_inc(tm, 8'h59);
            if (c) {c, th} = bcd_inc(th, 8'h23);
        end
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        th = h; tm = m; ts = s;
        TIME_H = h; TIME_M = m; TIME_S = s;
    endtask

    task automatic tick(input logic [3:0] exp_rc);
        @(negedge CP);
        TIME_H = th; TIME_M = tm; TIME_S = ts;
        TICK = 1'b1;
        push(1, $sformatf("tick %h:%h:%h", th, tm, ts), exp_rc, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge CP);
        TICK = 1'b0;
        adv_time();
    endtask

    task automatic write_ch(input int ch, input logic [7:0] h, input logic [7:0] m,
                            input logic en, input logic with_tick, input logic [3:0] exp_rc);
        @(negedge CP);
        TIME_H = th; TIME_M = tm; TIME_S = ts;
        WE = 1'b1; WADDR = ch[1:0]; RADDR = ch[1:0];
        D_H = h; D_M = m; D_EN = en;
        TICK = with_tick;
        push(1, $sformatf("write ch%0d", ch), exp_rc, 1'b1, h, m, en);
        @(negedge CP);
        WE = 1'b0; TICK = 1'b0;
    endtask

    task automatic peek(input int ch, input logic [7:0] h, input logic [7:0] m,
                        input logic en, input logic [3:0] exp_rc);
        @(negedge CP);
        RADDR = ch[1:0];
        push(1, $sformatf("peek ch%0d", ch), exp_rc, 1'b1, h, m, en);
        @(negedge CP);
    endtask

    // Button pressed and held 3 cycles: no effect after one edge, effect
    // after two, and still the same after three (held button acts once).
    task automatic press(input logic s, input logic z, input string name,
                         input logic [3:0] before_rc, input logic [3:0] after_rc);
        @(negedge CP);
        TIME_H = th; TIME_M = tm; TIME_S = ts;
        STOP = s; SNOOZE = z;
        push(1, {name, " +1"}, before_rc, 1'b0, 8'h00, 8'h00, 1'b0);
        push(2, {name, " +2"}, after_rc, 1'b0, 8'h00, 8'h00, 1'b0);
        push(3, {name, " held"}, after_rc, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge CP);
        STOP = 1'b0; SNOOZE = 1'b0;
        @(negedge CP);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_time(8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge CP);
        CR = 1'b1;

        // Reset state
        for (int i = 0; i < 4; i++) peek(i, 8'h00, 8'h00, 1'b0, 4'b0000);

        // Basic ring on ch0 at 07:30 for 60 ticks
        write_ch(0, 8'h07, 8'h30, 1'b1, 1'b0, 4'b0000);
        set_time(8'h07, 8'h29, 8'h58);
        repeat (68) tick((th == 8'h07 && tm == 8'h30) ? 4'b0001 : 4'b0000);

        // Snooze chain on ch1 across midnight
        write_ch(1, 8'h23, 8'h58, 1'b1, 1'b0, 4'b0000);
        set_time(8'h23, 8'h57, 8'h59);
        repeat (11) tick((th == 8'h23 && tm == 8'h58) ? 4'b0010 : 4'b0000);
        press(1'b0, 1'b1, "snooze1", 4'b0010, 4'b0000);
        set_time(8'h00, 8'h02, 8'h59);
        tick(4'b0000);
        tick(4'b0010);
        tick(4'b0010);
        press(1'b0, 1'b1, "snooze2", 4'b0010, 4'b0000);
        set_time(8'h00, 8'h07, 8'h00);
        tick(4'b0000);
        set_time(8'h00, 8'h08, 8'h00);
        tick(4'b0010);
        press(1'b0, 1'b1, "snooze3", 4'b0010, 4'b0000);
        set_time(8'h00, 8'h13, 8'h00);
        tick(4'b0010);
        press(1'b0, 1'b1, "snooze4", 4'b0010, 4'b0000);
        set_time(8'h00, 8'h13, 8'h00);
        tick(4'b0000);
        set_time(8'h00, 8'h18, 8'h00);
        tick(4'b0000);

        // Two channels at 06:00, STOP clears both
        write_ch(0, 8'h06, 8'h00, 1'b1, 1'b0, 4'b0000);
        write_ch(2, 8'h06, 8'h00, 1'b1, 1'b0, 4'b0000);
        set_time(8'h05, 8'h59, 8'h59);
        tick(4'b0000);
        tick(4'b0101);
        tick(4'b0101);
        press(1'b1, 1'b0, "stop", 4'b0101, 4'b0000);
        tick(4'b0000);

        // STOP and SNOOZE together: no snooze target at 06:10
        write_ch(0, 8'h06, 8'h05, 1'b1, 1'b0, 4'b0000);
        set_time(8'h06, 8'h05, 8'h00);
        tick(4'b0001);
        press(1'b1, 1'b1, "stop+snooze", 4'b0001, 4'b0000);
        set_time(8'h06, 8'h10, 8'h00);
        tick(4'b0000);

        // Write coinciding with a match: new setting wins
        write_ch(3, 8'h12, 8'h00, 1'b1, 1'b0, 4'b0000);
        set_time(8'h12, 8'h00, 8'h00);
        write_ch(3, 8'h13, 8'h00, 1'b1, 1'b1, 4'b0000);
        tick(4'b0000);

        // D_EN=0 write silences a ringing channel; disabled setting never rings
        write_ch(3, 8'h12, 8'h00, 1'b1, 1'b0, 4'b0000);
        set_time(8'h12, 8'h00, 8'h00);
        tick(4'b1000);
        tick(4'b1000);
        write_ch(3, 8'h12, 8'h00, 1'b0, 1'b0, 4'b0000);
        tick(4'b0000);
        set_time(8'h12, 8'h00, 8'h00);
        tick(4'b0000);

        // Out-of-range BCD stored as given
        write_ch(2, 8'h2A, 8'h7F, 1'b1, 1'b0, 4'b0000);

        // Asynchronous reset mid-ring
        write_ch(1, 8'h14, 8'h00, 1'b1, 1'b0, 4'b0000);
        set_time(8'h14, 8'h00, 8'h00);
        tick(4'b0010);
        tick(4'b0010);
        @(negedge CP);
        RADDR = 2'd1;
        @(posedge CP);
        #1;
        CR = 1'b0;
        push(0, "async reset", 4'b0000, 1'b1, 8'h00, 8'h00, 1'b0);
        @(posedge CP);
        #1;
        CR = 1'b1;
        for (int i = 0; i < 4; i++) peek(i, 8'h00, 8'h00, 1'b0, 4'b0000);

        // Drain scoreboard
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CP);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
